// File: rtl/ahbpassthru_pkg.sv
// Shared definitions for the AHB pass-through to an off-chip request/ack port:
// bus encodings, controller state encoding and the timeout counter width.
package ahbpassthru_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR1 = 3'd4,
    ST_ERR2 = 3'd5
  } state_e;

  localparam int CNT_W = 8;

endpackage

// File: rtl/ahbpassthru_offchip_if.sv
// Bus bundle: AHB slave-side signals plus the off-chip request/response port.
// The slave modport is the bridge's view; master is the surrounding system.
interface ahbpassthru_offchip_if #(parameter int DATAWIDTH = 32);

  logic                 hsel;
  logic [31:0]          haddr;
  logic                 hwrite;
  logic [1:0]           htrans;
  logic [2:0]           hsize;
  logic [DATAWIDTH-1:0] hwdata;
  logic                 hready;
  logic                 hready_o;
  logic [1:0]           hresp;
  logic [DATAWIDTH-1:0] hrdata;

  logic                 x_req;
  logic [31:0]          x_addr;
  logic                 x_write;
  logic [2:0]           x_size;
  logic [DATAWIDTH-1:0] x_wdata;
  logic [DATAWIDTH-1:0] x_rdata;
  logic                 x_ack;
  logic                 x_err;

  modport slave (
    input  hsel, haddr, hwrite, htrans, hsize, hwdata, hready,
    output hready_o, hresp, hrdata,
    output x_req, x_addr, x_write, x_size, x_wdata,
    input  x_rdata, x_ack, x_err
  );

  modport master (
    output hsel, haddr, hwrite, htrans, hsize, hwdata, hready,
    input  hready_o, hresp, hrdata,
    input  x_req, x_addr, x_write, x_size, x_wdata,
    output x_rdata, x_ack, x_err
  );

endinterface

// File: rtl/ahbpassthru_tmo.sv
// Saturating wait-cycle counter; expire flags that the count has reached a
// non-zero limit (a zero limit never expires).
module ahbpassthru_tmo
  import ahbpassthru_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (limit != '0) && (cnt_q == limit);

endmodule

// File: rtl/ahbpassthru_offchip.sv
// AHB slave that forwards each accepted transfer to an off-chip req/ack port,
// stretching the data phase until the far side acknowledges, errors or times out.
module ahbpassthru_offchip
  import ahbpassthru_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  ahbpassthru_offchip_if.slave  bus
);

  localparam logic [2:0]       MAX_SIZE  = 3'($clog2(DATAWIDTH / 8));
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);

  state_e               state_q, state_d;
  logic                 x_req_q, x_req_d;
  logic [31:0]          x_addr_q, x_addr_d;
  logic                 x_write_q, x_write_d;
  logic [2:0]           x_size_q, x_size_d;
  logic [DATAWIDTH-1:0] x_wdata_q, x_wdata_d;
  logic [DATAWIDTH-1:0] hrdata_q, hrdata_d;

  logic accept;
  logic size_bad;
  logic tmo_clr;
  logic tmo_en;
  logic tmo_expire;
  logic hready_o;
  logic [1:0] hresp;

  assign accept   = bus.hsel && bus.hready &&
                    ((bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ));
  assign size_bad = bus.hsize > MAX_SIZE;
  assign tmo_clr  = (state_q == ST_ADDR);
  assign tmo_en   = (state_q == ST_WAIT);

  ahbpassthru_tmo u_tmo (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .limit  (TMO_LIMIT),
    .expire (tmo_expire)
  );

  // NOTE: every signal written here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    x_req_d   = x_req_q;
    x_addr_d  = x_addr_q;
    x_write_d = x_write_q;
    x_size_d  = x_size_q;
    x_wdata_d = x_wdata_q;
    hrdata_d  = hrdata_q;
    hready_o  = 1'b1;
    hresp     = HRESP_OKAY;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (state_q == ST_ERR2) hresp = HRESP_ERROR;
        if (accept) begin
          x_addr_d  = bus.haddr;
          x_write_d = bus.hwrite;
          x_size_d  = bus.hsize;
          // Oversized transfers never reach the far side.
          state_d   = size_bad ? ST_ERR1 : ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        hready_o  = 1'b0;
        x_wdata_d = bus.hwdata;
        x_req_d   = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        hready_o = 1'b0;
        // Error beats a simultaneous ack; responses only count while requesting.
        if (x_req_q && bus.x_err) begin
          x_req_d = 1'b0;
          state_d = ST_ERR1;
        end else if (x_req_q && bus.x_ack) begin
          hrdata_d = bus.x_rdata;
          x_req_d  = 1'b0;
          state_d  = ST_DONE;
        end else if (tmo_expire) begin
          x_req_d = 1'b0;
          state_d = ST_ERR1;
        end
      end
      ST_ERR1: begin
        hready_o = 1'b0;
        hresp    = HRESP_ERROR;
        state_d  = ST_ERR2;
      end
      default: begin
        x_req_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      x_req_q   <= 1'b0;
      x_addr_q  <= '0;
      x_write_q <= 1'b0;
      x_size_q  <= '0;
      x_wdata_q <= '0;
      hrdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      x_req_q   <= x_req_d;
      x_addr_q  <= x_addr_d;
      x_write_q <= x_write_d;
      x_size_q  <= x_size_d;
      x_wdata_q <= x_wdata_d;
      hrdata_q  <= hrdata_d;
    end
  end

  assign bus.hready_o = hready_o;
  assign bus.hresp    = hresp;
  assign bus.hrdata   = hrdata_q;
  assign bus.x_req    = x_req_q;
  assign bus.x_addr   = x_addr_q;
  assign bus.x_write  = x_write_q;
  assign bus.x_size   = x_size_q;
  assign bus.x_wdata  = x_wdata_q;

endmodule

// File: tb/tb_ahbpassthru_offchip.sv
// Scoreboard bench: each issued transfer pushes its expected response; the
// response watcher pops and compares once the bridge completes the transfer.
module tb_ahbpassthru_offchip;
  import ahbpassthru_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  ahbpassthru_offchip_if #(.DATAWIDTH(32)) bus ();
  ahbpassthru_offchip_if #(.DATAWIDTH(32)) bus_t ();

  ahbpassthru_offchip #(.DATAWIDTH(32), .TIMEOUT(255)) dut (
    .clk (clk), .rstn (rstn), .bus (bus)
  );

  // Second instance with a short timeout, fed the same stimulus.
  ahbpassthru_offchip #(.DATAWIDTH(32), .TIMEOUT(4)) dut_t (
    .clk (clk), .rstn (rstn), .bus (bus_t)
  );

  assign bus.hready    = bus.hready_o;
  assign bus_t.hready  = bus_t.hready_o;
  assign bus_t.hsel    = bus.hsel;
  assign bus_t.haddr   = bus.haddr;
  assign bus_t.hwrite  = bus.hwrite;
  assign bus_t.htrans  = bus.htrans;
  assign bus_t.hsize   = bus.hsize;
  assign bus_t.hwdata  = bus.hwdata;
  assign bus_t.x_rdata = bus.x_rdata;
  assign bus_t.x_ack   = bus.x_ack;
  assign bus_t.x_err   = bus.x_err;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          req;
    int          low;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int req_rise_cyc;
  int done_cyc;
  logic [31:0] model_hrdata = 32'h0;

  // Off-chip responder controls
  int          ack_at   = 0;
  bit          use_err  = 0;
  bit          use_both = 0;
  bit          stray    = 0;
  logic [31:0] rd_val   = 32'h0;
  int          req_cnt  = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    bus.x_rdata = stray ? 32'hBAD0_BAD0 : rd_val;
    if (bus.x_req) begin
      req_cnt++;
      bus.x_ack = (ack_at != 0) && (req_cnt == ack_at) && (!use_err || use_both);
      bus.x_err = (ack_at != 0) && (req_cnt == ack_at) && (use_err || use_both);
    end else begin
      req_cnt   = 0;
      bus.x_ack = stray;
      bus.x_err = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  task automatic drive_addr(input logic [31:0] addr, input logic write,
                            input logic [2:0] size, input logic [31:0] wdata);
    bus.hsel   = 1'b1;
    bus.haddr  = addr;
    bus.hwrite = write;
    bus.htrans = HTRANS_NONSEQ;
    bus.hsize  = size;
    @(negedge clk);
    bus.hsel   = 1'b0;
    bus.htrans = HTRANS_IDLE;
    bus.hwdata = wdata;
  endtask

  task automatic issue(input logic [31:0] addr, input logic write, input logic [2:0] size,
                       input logic [31:0] wdata, input int ack, input bit err,
                       input bit both, input logic [31:0] rd);
    exp_t e;
    ack_at = ack; use_err = err; use_both = both; rd_val = rd;
    e.addr = addr; e.write = write; e.size = size; e.wdata = wdata;
    if (size > 3'd2) begin
      e.req = 0; e.resp = HRESP_ERROR; e.low = 1;
    end else if (err || both) begin
      e.req = 1; e.resp = HRESP_ERROR; e.low = ack + 2;
    end else begin
      e.req = 1; e.resp = HRESP_OKAY; e.low = ack + 1;
      model_hrdata = rd;
    end
    e.rdata = model_hrdata;
    exp_q.push_back(e);
    drive_addr(addr, write, size, wdata);
  endtask

  task automatic wait_resp(input string tag);
    exp_t e;
    int   low  = 0;
    bit   seen = 0;
    bit   err1 = 0;
    bit   done = 0;
    e = exp_q.pop_front();
    for (int i = 0; i < 100 && !done; i++) begin
      if (bus.x_req && !seen) begin
        seen = 1;
        req_rise_cyc = cyc;
        check({tag, "_xaddr"},  bus.x_addr,  e.addr);
        check({tag, "_xwrite"}, bus.x_write, e.write);
        check({tag, "_xsize"},  bus.x_size,  e.size);
        check({tag, "_xwdata"}, bus.x_wdata, e.wdata);
      end
      if (bus.hready_o) begin
        done = 1;
        done_cyc = cyc;
      end else begin
        low++;
        if (bus.hresp == HRESP_ERROR) err1 = 1;
        @(negedge clk);
      end
    end
    check({tag, "_done"},  done,       1);
    check({tag, "_low"},   low,        e.low);
    check({tag, "_resp"},  bus.hresp,  e.resp);
    check({tag, "_rdata"}, bus.hrdata, e.rdata);
    check({tag, "_req"},   seen,       e.req);
    if (e.resp == HRESP_ERROR) check({tag, "_err1"}, err1, 1);
  endtask

  initial begin
    int prev_done;
    rstn = 1'b0;
    bus.hsel = 1'b0; bus.haddr = '0; bus.hwrite = 1'b0;
    bus.htrans = HTRANS_IDLE; bus.hsize = '0; bus.hwdata = '0;
    repeat (3) @(negedge clk);

    check("rst_hready", bus.hready_o, 1);
    check("rst_hresp",  bus.hresp,    HRESP_OKAY);
    check("rst_xreq",   bus.x_req,    0);
    check("rst_hrdata", bus.hrdata,   0);
    check("rst_xaddr",  bus.x_addr,   0);
    check("rst_xwdata", bus.x_wdata,  0);
    check("rst_xwrite", bus.x_write,  0);
    check("rst_xsize",  bus.x_size,   0);

    rstn = 1'b1;
    @(negedge clk);

    // Selected with BUSY: zero-wait OKAY, no request
    bus.hsel = 1'b1; bus.htrans = HTRANS_BUSY;
    @(negedge clk);
    check("busy_hready", bus.hready_o, 1);
    check("busy_hresp",  bus.hresp,    HRESP_OKAY);
    check("busy_xreq",   bus.x_req,    0);
    bus.hsel = 1'b0; bus.htrans = HTRANS_IDLE;
    @(negedge clk);

    issue(32'h4000_0010, 1'b0, 3'd2, 32'h0, 1, 0, 0, 32'hDEAD_BEEF);
    wait_resp("rd_min");

    @(negedge clk);
    issue(32'h8000_0000, 1'b1, 3'd2, 32'h1234_5678, 5, 0, 0, 32'h5555_AAAA);
    wait_resp("wr5");

    // Stray ack with no request outstanding must not disturb hrdata
    @(negedge clk);
    stray = 1;
    repeat (2) @(negedge clk);
    stray = 0;
    @(negedge clk);
    check("stray_hrdata", bus.hrdata,   model_hrdata);
    check("stray_hready", bus.hready_o, 1);

    // Back-to-back reads accepted in DONE
    issue(32'h0000_0100, 1'b0, 3'd2, 32'h0, 1, 0, 0, 32'hA5A5_0001);
    wait_resp("b2b_a");
    prev_done = done_cyc;
    issue(32'h0000_0104, 1'b0, 3'd1, 32'h0, 2, 0, 0, 32'h0BAD_CAFE);
    wait_resp("b2b_b");
    check("b2b_gap", req_rise_cyc - prev_done, 2);

    @(negedge clk);
    issue(32'h2000_0000, 1'b0, 3'd2, 32'h0, 3, 1, 0, 32'h1111_2222);
    wait_resp("xerr");

    @(negedge clk);
    issue(32'h2000_0004, 1'b0, 3'd2, 32'h0, 1, 0, 1, 32'h3333_4444);
    wait_resp("ackerr");

    // Oversized, then a read accepted straight out of ERR2
    @(negedge clk);
    issue(32'h3000_0000, 1'b0, 3'd3, 32'h0, 1, 0, 0, 32'h0);
    wait_resp("size");
    prev_done = done_cyc;
    issue(32'h3000_0008, 1'b0, 3'd0, 32'h0, 1, 0, 0, 32'h7777_8888);
    wait_resp("after_err");
    check("err_b2b_gap", req_rise_cyc - prev_done, 2);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      issue($urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)), $urandom,
            int'($urandom_range(1, 4)), 0, 0, $urandom);
      wait_resp($sformatf("rand%0d", i));
    end

    // Timeout on the TIMEOUT=4 instance: expires when the count reaches 4,
    // i.e. after five request cycles (counts 0..4).
    @(negedge clk);
    ack_at = 0; use_err = 0; use_both = 0;
    begin
      int  tcnt  = 0;
      int  tlow  = 0;
      bit  terr1 = 0;
      bit  tdone = 0;
      drive_addr(32'h1000_0000, 1'b0, 3'd2, 32'h0);
      for (int i = 0; i < 50 && !tdone; i++) begin
        if (bus_t.x_req) tcnt++;
        if (bus_t.hready_o) begin
          tdone = 1;
        end else begin
          tlow++;
          if (bus_t.hresp == HRESP_ERROR) terr1 = 1;
          @(negedge clk);
        end
      end
      check("tmo_done",  tdone,         1);
      check("tmo_reqs",  tcnt,          5);
      check("tmo_low",   tlow,          7);
      check("tmo_err1",  terr1,         1);
      check("tmo_resp",  bus_t.hresp,   HRESP_ERROR);
      check("tmo_xreq",  bus_t.x_req,   0);
    end

    // Main instance is still waiting; reset aborts it asynchronously
    check("rstp_pre_xreq", bus.x_req, 1);
    rstn = 1'b0;
    #1;
    check("rstp_xreq",   bus.x_req,    0);
    check("rstp_hready", bus.hready_o, 1);
    check("rstp_hresp",  bus.hresp,    HRESP_OKAY);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("post_hready", bus.hready_o, 1);
    check("post_hresp",  bus.hresp,    HRESP_OKAY);
    check("post_xreq",   bus.x_req,    0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
